// File: rtl/jtsdram_check.sv
// Read-back checker: sweeps all four SDRAM banks through the prog read port and
// compares each word with the bank data generators. Optional macro JTSDRAM_CHECK_STOP_EN stops at first error.
module jtsdram_check #(
  parameter int unsigned AW   = 22,
  parameter int unsigned TOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic          bad,
  output logic          tout,
  output logic [15:0]   err_cnt,
  output logic [AW+1:0] err_addr,
  input  logic [15:0]   ba0_data,
  input  logic [15:0]   ba1_data,
  input  logic [15:0]   ba2_data,
  input  logic [15:0]   ba3_data,
  output logic [AW-1:0] prog_addr,
  output logic [1:0]    prog_ba,
  output logic          prog_rd,
  input  logic [15:0]   prog_dout,
  input  logic          prog_rdy
);

  localparam int unsigned TW = 8;
`ifdef JTSDRAM_CHECK_STOP_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT, NEXT} state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [15:0]     r_exp;
  logic [15:0]     w_exp_sel;
  logic [AW+1:0]   w_addr;
  logic            w_last;
  logic            w_mis;
  logic            w_tmo;

  assign w_addr = {prog_ba, prog_addr};
  assign w_last = &w_addr;
  assign w_mis  = prog_dout != r_exp;
  assign w_tmo  = TW'(r_timer + TW'(1)) == TW'(TOUT);

  // Expected word for the bank currently addressed
  always_comb begin
    w_exp_sel = ba0_data;
    case (prog_ba)
      2'd0:    w_exp_sel = ba0_data;
      2'd1:    w_exp_sel = ba1_data;
      2'd2:    w_exp_sel = ba2_data;
      default: w_exp_sel = ba3_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_exp     <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      bad       <= 1'b0;
      tout      <= 1'b0;
      err_cnt   <= '0;
      err_addr  <= '0;
      prog_addr <= '0;
      prog_ba   <= '0;
      prog_rd   <= 1'b0;
    end else if (start) begin
      // Restart wins over any in-flight acknowledge
      r_state   <= REQ;
      done      <= 1'b0;
      busy      <= 1'b1;
      bad       <= 1'b0;
      tout      <= 1'b0;
      err_cnt   <= '0;
      err_addr  <= '0;
      prog_addr <= '0;
      prog_ba   <= '0;
      prog_rd   <= 1'b0;
    end else begin
      case (r_state)
        REQ: begin
          r_exp   <= w_exp_sel;
          prog_rd <= 1'b1;
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (prog_rdy) begin
            prog_rd <= 1'b0;
            r_state <= NEXT;
            if (w_mis) begin
              bad <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= 16'(err_cnt + 16'd1);
              if (!bad) err_addr <= w_addr;
              if (STOP_EN) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= IDLE;
              end
            end
          end else if (w_tmo) begin
            prog_rd <= 1'b0;
            tout    <= 1'b1;
            bad     <= 1'b1;
            r_state <= NEXT;
            if (!bad) err_addr <= w_addr;
            if (STOP_EN) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_timer <= TW'(r_timer + TW'(1));
          end
        end
        NEXT: begin
          if (w_last) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            {prog_ba, prog_addr} <= (AW+2)'(w_addr + (AW+2)'(1));
            r_state <= REQ;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtsdram_check.sv
// Bench for jtsdram_check: SDRAM read model with programmable corruption, withheld
// acknowledges and mid-sweep restart; expected read addresses are queued per sweep.
module tb_jtsdram_check;

  localparam int unsigned AW   = 4;
  localparam int unsigned TOUT = 8;
  localparam int unsigned NW   = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          start_m;
  logic          start_r;
  logic          done, busy, bad, tout;
  logic [15:0]   err_cnt;
  logic [AW+1:0] err_addr;
  logic [15:0]   ba0_data, ba1_data, ba2_data, ba3_data;
  logic [AW-1:0] prog_addr;
  logic [1:0]    prog_ba;
  logic          prog_rd;
  logic [15:0]   prog_dout;
  logic          prog_rdy;

  logic          m_rdy, inj_rdy;
  logic [15:0]   m_dout, inj_dout;

  always #5 clk = ~clk;

  function automatic logic [15:0] gen(input logic [5:0] a);
    return 16'hC35A ^ {a, 4'b0000, a};
  endfunction

  assign ba0_data  = gen({2'd0, prog_addr});
  assign ba1_data  = gen({2'd1, prog_addr});
  assign ba2_data  = gen({2'd2, prog_addr});
  assign ba3_data  = gen({2'd3, prog_addr});
  assign start     = start_m | start_r;
  assign prog_rdy  = m_rdy | inj_rdy;
  assign prog_dout = inj_rdy ? inj_dout : m_dout;

  jtsdram_check #(.AW(AW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy), .bad(bad),
    .tout(tout), .err_cnt(err_cnt), .err_addr(err_addr),
    .ba0_data(ba0_data), .ba1_data(ba1_data), .ba2_data(ba2_data), .ba3_data(ba3_data),
    .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_rd(prog_rd),
    .prog_dout(prog_dout), .prog_rdy(prog_rdy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard of addresses the sweep must read, in order
  logic [5:0] q_addr[$];

  function automatic void fill_q();
    q_addr.delete();
    for (int i = 0; i < NW; i++) q_addr.push_back(6'(i));
  endfunction

  int         rd_cnt = 0;
  int         hi_cnt = 0;
  int         hold_dur = 0;
  int         m_cnt = -1;
  logic       prev_rd = 1'b0;
  logic [5:0] cur = '0;
  logic [5:0] cor0 = '0, cor1 = '0, hold_addr = '0;
  bit         cor_en = 0, hold_en = 0, restart_arm = 0, restart_fired = 0;

  // Memory model: acknowledges two cycles after each read request rises
  always @(negedge clk) begin
    m_rdy   = 1'b0;
    start_r = 1'b0;
    if (prog_rd) hi_cnt++;
    if (!prog_rd && prev_rd && hold_en && cur == hold_addr) hold_dur = hi_cnt;
    if (prog_rd && !prev_rd) begin
      hi_cnt = 1;
      rd_cnt++;
      cur = {prog_ba, prog_addr};
      if (q_addr.size() == 0) chk("rd_extra", 32'(cur), 32'hFFFF_FFFF);
      else chk("rd_addr", 32'(cur), 32'(q_addr.pop_front()));
      if (!(hold_en && cur == hold_addr)) m_cnt = 2;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_cnt  = -1;
        m_rdy  = 1'b1;
        m_dout = gen(cur);
        if (cor_en && cur == cor0) m_dout = m_dout ^ 16'h8000;
        if (cor_en && cur == cor1) m_dout = m_dout ^ 16'h0001;
        if (restart_arm && cur[5:4] == 2'd2) begin
          start_r       = 1'b1;
          restart_arm   = 0;
          restart_fired = 1;
          cor_en        = 0;
          rd_cnt        = 0;
          fill_q();
        end
      end
    end
    prev_rd = prog_rd;
  end

  task automatic start_sweep();
    fill_q();
    rd_cnt = 0;
    @(negedge clk) start_m = 1'b1;
    @(negedge clk) start_m = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000 && !done; i++) @(posedge clk);
    if (!done) chk(tag, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_m = 1'b0; start_r = 1'b0; m_rdy = 1'b0; inj_rdy = 1'b0;
    m_dout = '0; inj_dout = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {28'd0, done, busy, bad, tout}, 32'd0);
    chk("rst_cnt", 32'(err_cnt), 32'd0);
    chk("rst_eaddr", 32'(err_addr), 32'd0);
    chk("rst_addr", {25'd0, prog_rd, prog_ba, prog_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifdef JTSDRAM_CHECK_STOP_EN
    cor0 = 6'h32; cor1 = 6'h32; cor_en = 1;
    start_sweep();
    wait_done("stop_done_to");
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_ba", 32'(prog_ba), 32'd3);
    chk("stop_addr", 32'(prog_addr), 32'd2);
    chk("stop_cnt", 32'(err_cnt), 32'd1);
    chk("stop_eaddr", 32'(err_addr), 32'h32);
    chk("stop_rds", 32'(rd_cnt), 32'd51);
    repeat (30) @(negedge clk);
    chk("stop_no_more_rd", 32'(rd_cnt), 32'd51);
    chk("stop_busy", 32'(busy), 32'd0);
    cor_en = 0;
`else
    // Clean sweep
    start_sweep();
    chk("start_busy", {30'd0, busy, done}, 32'd2);
    wait_done("clean_done_to");
    chk("clean_flags", {29'd0, done, bad, tout}, 32'd4);
    chk("clean_cnt", 32'(err_cnt), 32'd0);
    chk("clean_rds", 32'(rd_cnt), 32'(NW));
    chk("clean_final", {26'd0, prog_ba, prog_addr}, 32'h3F);
    chk("clean_q", 32'(q_addr.size()), 32'd0);

    // Stray acknowledge while idle
    inj_dout = 16'hDEAD;
    @(negedge clk) inj_rdy = 1'b1;
    @(negedge clk) inj_rdy = 1'b0;
    @(negedge clk);
    chk("idle_rdy", {15'd0, done, bad, err_cnt}, {15'd0, 1'b1, 1'b0, 16'd0});

    // Two corrupted words
    cor0 = 6'h15; cor1 = 6'h20; cor_en = 1;
    start_sweep();
    wait_done("cor_done_to");
    chk("cor_cnt", 32'(err_cnt), 32'd2);
    chk("cor_flags", {29'd0, done, bad, tout}, 32'd6);
    chk("cor_eaddr", 32'(err_addr), 32'h15);
    cor_en = 0;

    // Withheld acknowledge -> timeout
    hold_addr = 6'h03; hold_en = 1;
    start_sweep();
    wait_done("tmo_done_to");
    chk("tmo_flags", {29'd0, done, bad, tout}, 32'd7);
    chk("tmo_eaddr", 32'(err_addr), 32'h03);
    chk("tmo_cnt", 32'(err_cnt), 32'd0);
    chk("tmo_dur", 32'(hold_dur), 32'(TOUT));
    chk("tmo_rds", 32'(rd_cnt), 32'(NW));
    hold_en = 0;

    // Restart mid-sweep in bank 2 with an error already flagged
    cor0 = 6'h15; cor1 = 6'h15; cor_en = 1; restart_arm = 1; restart_fired = 0;
    start_sweep();
    for (int i = 0; i < 3000 && !restart_fired; i++) @(posedge clk);
    if (!restart_fired) chk("rs_fire_to", 32'(restart_fired), 32'd1);
    @(negedge clk);
    chk("rs_clear", {15'd0, bad, err_cnt}, 32'd0);
    chk("rs_addr", {26'd0, prog_ba, prog_addr}, 32'd0);
    chk("rs_busy", {30'd0, busy, done}, 32'd2);
    wait_done("rs_done_to");
    chk("rs_end", {13'd0, done, bad, tout, err_cnt}, {13'd0, 3'b100, 16'd0});
    chk("rs_rds", 32'(rd_cnt), 32'(NW));
    chk("rs_q", 32'(q_addr.size()), 32'd0);

    // Stray acknowledge during REQ
    fill_q();
    rd_cnt = 0;
    @(negedge clk) start_m = 1'b1;
    @(negedge clk) begin start_m = 1'b0; inj_rdy = 1'b1; end
    @(negedge clk) inj_rdy = 1'b0;
    wait_done("req_done_to");
    chk("req_rdy", {15'd0, bad, err_cnt}, 32'd0);
    chk("req_rds", 32'(rd_cnt), 32'(NW));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
